// File: rtl/niosii_soc_stream_mem_writer_pkg.sv
// Shared types and constants for the byte-stream to on-chip RAM writer.
// The writer packs LANES bytes per RAM word; the lane count is fixed.
package niosii_soc_stream_pkg;

  localparam int LANES  = 4;
  localparam int BYTE_W = 8;
  localparam int DATA_W = LANES * BYTE_W;
  localparam int LANE_W = $clog2(LANES);
  localparam int POP_W  = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [POP_W-1:0] popcount(input logic [LANES-1:0] be);
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      cnt = cnt + {{(POP_W-1){1'b0}}, be[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/niosii_soc_stream_mem_writer_if.sv
// Avalon-ST sink plus Avalon-MM RAM write port of the stream writer.
// master = the writer itself, slave = the stream source / RAM side.
interface niosii_soc_stream_mem_writer_if #(
  parameter int ADDR_W = 13
);
  import niosii_soc_stream_pkg::*;

  logic [BYTE_W-1:0] sink_data;
  logic              sink_valid;
  logic              sink_eop;
  logic              sink_ready;

  logic [ADDR_W-1:0] mem_address;
  logic [LANES-1:0]  mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;

  modport master (
    input  sink_data, sink_valid, sink_eop,
    output sink_ready,
    output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
  );

  modport slave (
    output sink_data, sink_valid, sink_eop,
    input  sink_ready,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
  );

endinterface

// File: rtl/niosii_soc_stream_mem_writer_packer.sv
// Little-endian byte packer: drops each loaded byte into the current lane,
// accumulates lane enables, and clears back to lane 0 with zeroed data.
module niosii_soc_byte_packer
  import niosii_soc_stream_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [DATA_W-1:0] o_word,
  output logic [LANES-1:0]  o_be,
  output logic              o_lane_last
);

  logic [LANE_W-1:0] r_lane;
  logic [BYTE_W-1:0] r_byte [LANES];
  logic              r_en   [LANES];

  always_ff @(posedge clk) begin
    if (!reset_n || i_clear) begin
      r_lane <= '0;
    end else if (i_load) begin
      r_lane <= r_lane + LANE_W'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      // Unfilled lanes stay zero so a short final word carries clean data.
      always_ff @(posedge clk) begin
        if (!reset_n || i_clear) begin
          r_byte[gi] <= '0;
          r_en[gi]   <= 1'b0;
        end else if (i_load && (r_lane == LANE_W'(gi))) begin
          r_byte[gi] <= i_byte;
          r_en[gi]   <= 1'b1;
        end
      end

      assign o_word[gi*BYTE_W +: BYTE_W] = r_byte[gi];
      assign o_be[gi]                    = r_en[gi];
    end
  endgenerate

  assign o_lane_last = (r_lane == LANE_W'(LANES - 1));

endmodule

// File: rtl/niosii_soc_stream_mem_writer.sv
// Avalon-ST byte stream to on-chip RAM writer: packs bytes into words and
// issues one single-cycle write per word until byte_count or sink_eop.
module niosii_soc_stream_mem_writer
  import niosii_soc_stream_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int CNT_W  = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  byte_count,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bytes_written,
  niosii_soc_stream_mem_writer_if.master bus
);

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_remaining;
  logic [CNT_W-1:0]  r_bytes_written;
  logic              r_eop_seen;

  logic              w_start;
  logic              w_accept;
  logic              w_last_beat;
  logic [DATA_W-1:0] w_word;
  logic [LANES-1:0]  w_be;
  logic              w_lane_last;

  assign w_start     = (r_state == IDLE) && start;
  assign w_accept    = (r_state == FILL) && bus.sink_valid;
  assign w_last_beat = w_accept &&
                       (w_lane_last || (r_remaining == CNT_W'(1)) || bus.sink_eop);

  niosii_soc_byte_packer u_packer (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_clear     (w_start || (r_state == WRITE)),
    .i_load      (w_accept),
    .i_byte      (bus.sink_data),
    .o_word      (w_word),
    .o_be        (w_be),
    .o_lane_last (w_lane_last)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_next = (byte_count == '0) ? DONE : FILL;
      FILL:    if (w_last_beat) w_state_next = WRITE;
      WRITE:   w_state_next = ((r_remaining == '0) || r_eop_seen) ? DONE : FILL;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Address and byte tally advance on the edge that commits the RAM write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr          <= '0;
      r_remaining     <= '0;
      r_bytes_written <= '0;
      r_eop_seen      <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr          <= base_addr;
        r_remaining     <= byte_count;
        r_bytes_written <= '0;
        r_eop_seen      <= 1'b0;
      end
      if (w_accept) begin
        r_remaining <= r_remaining - CNT_W'(1);
        if (bus.sink_eop) r_eop_seen <= 1'b1;
      end
      if (r_state == WRITE) begin
        r_addr          <= r_addr + ADDR_W'(1);
        r_bytes_written <= r_bytes_written + CNT_W'(popcount(w_be));
      end
    end
  end

  assign busy               = (r_state == FILL) || (r_state == WRITE);
  assign done               = (r_state == DONE);
  assign bytes_written      = r_bytes_written;
  assign bus.sink_ready     = (r_state == FILL);
  assign bus.mem_chipselect = (r_state == WRITE);
  assign bus.mem_write      = (r_state == WRITE);
  assign bus.mem_address    = r_addr;
  assign bus.mem_byteenable = w_be;
  assign bus.mem_writedata  = w_word;
  assign bus.mem_clken      = 1'b1;

endmodule

// File: tb/tb_niosii_soc_stream_mem_writer.sv
// Bench for the stream-to-RAM writer: a word-level model predicts every RAM
// write and the final byte tally; a monitor checks each write as it happens.
module tb_niosii_soc_stream_mem_writer;

  localparam int ADDR_W = 13;
  localparam int CNT_W  = 15;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [12:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  byte_count;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  bytes_written;

  niosii_soc_stream_mem_writer_if #(.ADDR_W(ADDR_W)) bus ();

  niosii_soc_stream_mem_writer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .base_addr     (base_addr),
    .byte_count    (byte_count),
    .busy          (busy),
    .done          (done),
    .bytes_written (bytes_written),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int  total = 0;
  int  bad   = 0;
  wr_t exp_q[$];
  wr_t model_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: the first n bytes, 4 per word little-endian, consecutive word addresses mod 8192.
  function automatic void model_build(input logic [12:0] base, input byte_q_t bytes, input int n);
    wr_t w;
    model_q.delete();
    for (int k = 0; k * 4 < n; k++) begin
      w.addr = 13'((int'(base) + k) % 8192);
      w.data = '0;
      w.be   = '0;
      for (int l = 0; l < 4; l++) begin
        if (k * 4 + l < n) begin
          w.data = w.data | (32'(bytes[k*4+l]) << (8 * l));
          w.be   = w.be | 4'(1 << l);
        end
      end
      model_q.push_back(w);
    end
  endfunction

  // Monitor: every RAM write must match the head of the predicted queue.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (bus.mem_write !== bus.mem_chipselect)
        check("cs_eq_write", 64'(bus.mem_chipselect), 64'(bus.mem_write));
      if (bus.mem_write === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(bus.mem_address), 64'h1_0000);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          $display("wr addr=%h data=%h be=%h", bus.mem_address, bus.mem_writedata, bus.mem_byteenable);
          check("wr_addr", 64'(bus.mem_address), 64'(e.addr));
          check("wr_data", 64'(bus.mem_writedata), 64'(e.data));
          check("wr_be", 64'(bus.mem_byteenable), 64'(e.be));
          check("wr_no_ready", 64'(bus.sink_ready), 64'd0);
        end
      end
    end
  end

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, 64'({busy, done, bus.sink_ready, bus.mem_chipselect, bus.mem_write,
                                bus.mem_byteenable}), 64'd0);
    check({name, "_data"}, 64'({bus.mem_address, bus.mem_writedata}), 64'd0);
    check({name, "_bw"}, 64'(bytes_written), 64'd0);
  endtask

  task automatic run_xfer(input logic [12:0] base, input int count, input int eop_idx,
                          input byte_q_t bytes, input bit gaps, input bit poke);
    int n_exp;
    int idx;
    int cyc;
    int budget;
    bit seen_done;
    bit v;
    n_exp = count;
    if (eop_idx >= 0 && eop_idx < count) n_exp = eop_idx + 1;
    model_build(base, bytes, n_exp);
    foreach (model_q[i]) exp_q.push_back(model_q[i]);
    budget = 8 * n_exp + 20;

    @(negedge clk);
    start      = 1'b1;
    base_addr  = base;
    byte_count = CNT_W'(count);
    @(negedge clk);
    start      = 1'b0;
    base_addr  = 13'($urandom);
    byte_count = 15'($urandom);

    idx = 0;
    cyc = 0;
    seen_done = 1'b0;
    while (!seen_done && cyc < budget) begin
      if (done === 1'b1) begin
        seen_done = 1'b1;
      end else begin
        check("busy", 64'(busy), 64'd1);
        start = poke && (cyc == 2);
        v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (idx >= bytes.size()) v = 1'b0;
        bus.sink_valid = v;
        bus.sink_data  = (idx < bytes.size()) ? bytes[idx] : 8'h00;
        bus.sink_eop   = v && (idx == eop_idx);
        if (v && bus.sink_ready === 1'b1) idx++;
        @(negedge clk);
        cyc++;
      end
    end
    bus.sink_valid = 1'b0;
    bus.sink_eop   = 1'b0;
    start          = 1'b0;

    $display("xfer base=%h count=%0d eop=%0d bytes=%0d cycles=%0d", base, count, eop_idx, n_exp, cyc);
    if (!seen_done) begin
      check("done_timeout", 64'd0, 64'd1);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      exp_q.delete();
      return;
    end
    check("accepted", 64'(idx), 64'(n_exp));
    check("bytes_written", 64'(bytes_written), 64'(n_exp));
    check("busy_at_done", 64'(busy), 64'd0);
    check("writes_left", 64'(exp_q.size()), 64'd0);
    if (!gaps) check("latency", 64'(cyc), 64'(n_exp + (n_exp + 3) / 4));
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
    check("bw_held", 64'(bytes_written), 64'(n_exp));
    exp_q.delete();
  endtask

  initial begin
    byte_q_t b;
    reset_n        = 1'b0;
    start          = 1'b0;
    base_addr      = '0;
    byte_count     = '0;
    bus.sink_valid = 1'b0;
    bus.sink_data  = '0;
    bus.sink_eop   = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("clken", 64'(bus.mem_clken), 64'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // 1) two full words
    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    model_build(13'h010, b, 8);
    check("pin1_n", 64'(model_q.size()), 64'd2);
    check("pin1_w0", 64'(model_q[0]), 64'({13'h010, 32'h04030201, 4'hF}));
    check("pin1_w1", 64'(model_q[1]), 64'({13'h011, 32'h08070605, 4'hF}));
    run_xfer(13'h010, 8, -1, b, 1'b0, 1'b0);

    // 2) partial last word
    model_build(13'h020, b, 6);
    check("pin2_w1", 64'(model_q[1]), 64'({13'h021, 32'h00000605, 4'h3}));
    run_xfer(13'h020, 6, -1, b, 1'b0, 1'b0);

    // 3) early eop
    b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    model_build(13'h040, b, 3);
    check("pin3_w0", 64'(model_q[0]), 64'({13'h040, 32'h00CCBBAA, 4'h7}));
    run_xfer(13'h040, 100, 2, b, 1'b0, 1'b0);

    // 4) address wrap
    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    model_build(13'h1FFF, b, 8);
    check("pin4_wrap", 64'(model_q[1].addr), 64'h0);
    run_xfer(13'h1FFF, 8, -1, b, 1'b1, 1'b0);

    // 5) zero count, then a start pulse while busy
    run_xfer(13'h0123, 0, -1, b, 1'b0, 1'b0);
    run_xfer(13'h0200, 8, -1, b, 1'b0, 1'b1);

    // 6) reset mid-transfer
    @(negedge clk);
    start = 1'b1; base_addr = 13'h155; byte_count = 15'd4;
    @(negedge clk);
    start = 1'b0;
    bus.sink_valid = 1'b1; bus.sink_data = 8'h5A;
    @(negedge clk);
    bus.sink_data = 8'hA5;
    @(negedge clk);
    bus.sink_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    reset_n = 1'b1;
    $display("xfer aborted by reset after 2 bytes");
    b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_xfer(13'h0300, 4, -1, b, 1'b0, 1'b0);

    // randomized transfers
    for (int t = 0; t < 14; t++) begin
      int cnt;
      int eop;
      cnt = ($urandom_range(0, 5) == 0) ? $urandom_range(25, 60) : $urandom_range(0, 24);
      eop = ($urandom_range(0, 2) == 0) ? $urandom_range(0, cnt + 1) : -1;
      b.delete();
      for (int i = 0; i < cnt + 4; i++) b.push_back(8'($urandom));
      run_xfer(13'($urandom), cnt, eop, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
